quick_spi_txn_queue: RTL and testbench
======================================

Name: quick_spi_txn_queue

Overview:
- Upstream command stage for the QuickSPI master engine.
- Buffers SPI transactions from a host-side valid/ready port in a FIFO. Each entry holds a slave select and a TX word.
- Issues transactions to the engine one at a time with a start pulse and waits for the engine's done pulse.
- Returns the captured RX word on a valid/ready response port, in command order.

Parameters:
- NUMBER_OF_SLAVES, 2, width of the one-hot slave select, matching the engine.
- DATA_WIDTH, 16, width of TX and RX words.
- DEPTH, 8, number of FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all logic samples on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_slave  in  NUMBER_OF_SLAVES  one-hot target slave.
- cmd_data  in  DATA_WIDTH  TX word.
- spi_start  out  1  one-cycle start pulse to the engine.
- spi_slave  out  NUMBER_OF_SLAVES  slave select to the engine, held stable for the whole transaction.
- spi_tx_data  out  DATA_WIDTH  TX word to the engine, held stable for the whole transaction.
- spi_done  in  1  one-cycle pulse from the engine: transaction complete.
- spi_rx_data  in  DATA_WIDTH  RX word; valid in the spi_done cycle.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts the response.
- rsp_slave  out  NUMBER_OF_SLAVES  slave select of the completed transaction.
- rsp_data  out  DATA_WIDTH  captured RX word.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (reset_n=0 at a rising edge): state IDLE; FIFO pointers and level=0; cmd_ready=1; spi_start=0; spi_slave=0; spi_tx_data=0; rsp_valid=0; rsp_slave=0; rsp_data=0. Reset mid-transaction discards the FIFO and the outstanding transaction. A spi_done pulse arriving after reset is ignored.
- Push: occurs when cmd_valid && cmd_ready at an edge.
  - cmd_ready = (level != DEPTH), registered.
  - A pop in the same cycle does not make room in that cycle; there is no full bypass.
- Pointers: log2(DEPTH) bits, wrap naturally. level is incremented and decremented independently. A simultaneous push and pop leaves level unchanged.
- FSM states: IDLE, ISSUE, WAIT_DONE, RESPOND.
  - IDLE: if level != 0, pop the head and load spi_slave and spi_tx_data, then go to ISSUE. If level == 0, stay in IDLE.
  - ISSUE: spi_start=1 for exactly this one cycle, then go to WAIT_DONE.
  - WAIT_DONE: on spi_done, capture spi_rx_data into rsp_data and spi_slave into rsp_slave, set rsp_valid=1, then go to RESPOND.
    - spi_done seen in any other state is ignored.
  - RESPOND: hold rsp_* stable while rsp_ready=0. When rsp_ready=1, clear rsp_valid and go to IDLE.
- Latency:
  - Command accepted at edge N into an empty, idle queue: spi_start is high in the cycle after edge N+2.
  - spi_done at edge M: rsp_valid is high after edge M.
  - rsp_ready at edge R: the next spi_start is high after edge R+2, if the FIFO is non-empty.
- Only one transaction is outstanding at a time; responses come back in FIFO order.
- Pushes continue during every FSM state while the FIFO is not full.
- cmd_slave is passed through unchecked; a non-one-hot value is the engine's concern.

Optional Feature:
- Macro: QUICK_SPI_TXN_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT_CYCLES (default 1024) and output rsp_error (1 bit, reset 0).
  - A 16-bit counter clears on entry to WAIT_DONE and counts each cycle in WAIT_DONE.
  - If it reaches TIMEOUT_CYCLES-1 without spi_done: go to RESPOND with rsp_error=1, rsp_data=0, and rsp_slave set to the current spi_slave.
  - rsp_error=0 for normal completions.
  - spi_done in the same cycle as the timeout: the done wins and rsp_error=0.
- When undefined: no counter and no rsp_error port; WAIT_DONE waits indefinitely.

Test Plan:
- Single transaction: reset, then push slave=2'b01, data=16'h1A6A. Check spi_start pulses once, two cycles after acceptance, with spi_tx_data=16'h1A6A. Drive spi_done with rx=16'h00C3 five cycles later → rsp_valid=1, rsp_data=16'h00C3, rsp_slave=2'b01.
- Fill and order: push 8 commands, data 0x0001..0x0008, with spi_done held off. cmd_ready=0 after the 8th push (level=8; the head leaves on the next pop). Service all 8 with rx=data^16'hFFFF → responses appear in order 0xFFFE..0xFFF7.
- Backpressure: hold rsp_ready=0 for 20 cycles after a response → rsp_* stable, no new spi_start. Release → next spi_start two cycles later.
- Simultaneous push/pop: level=3 and a push lands on the same edge as an IDLE pop → level stays 3 and the pushed data ends up in FIFO order.
- Reset mid-operation: with a transaction in WAIT_DONE and level=4, assert reset_n=0 for one edge → level=0, rsp_valid=0. A following stray spi_done produces no response.
- Timeout (QUICK_SPI_TXN_TIMEOUT_EN, TIMEOUT_CYCLES=16): never pulse spi_done → rsp_valid with rsp_error=1 and rsp_data=0, 16 cycles after entering WAIT_DONE.

Source files
------------

// File: rtl/quick_spi_txn_queue.sv
// Command FIFO and sequencer for the QuickSPI engine: one transaction in flight, in-order responses.
// Optional QUICK_SPI_TXN_TIMEOUT_EN adds a WAIT_DONE watchdog with an rsp_error flag.
module quick_spi_txn_queue #(
  parameter int unsigned NUMBER_OF_SLAVES = 2,
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned DEPTH            = 8
`ifdef QUICK_SPI_TXN_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES   = 1024
`endif
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [NUMBER_OF_SLAVES-1:0]   cmd_slave,
  input  logic [DATA_WIDTH-1:0]         cmd_data,
  output logic                          spi_start,
  output logic [NUMBER_OF_SLAVES-1:0]   spi_slave,
  output logic [DATA_WIDTH-1:0]         spi_tx_data,
  input  logic                          spi_done,
  input  logic [DATA_WIDTH-1:0]         spi_rx_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [NUMBER_OF_SLAVES-1:0]   rsp_slave,
  output logic [DATA_WIDTH-1:0]         rsp_data,
`ifdef QUICK_SPI_TXN_TIMEOUT_EN
  output logic                          rsp_error,
`endif
  output logic [$clog2(DEPTH):0]        level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone, StRespond} state_e;

  state_e r_state, w_state_d;

  logic [NUMBER_OF_SLAVES-1:0] r_mem_slave [DEPTH];
  logic [DATA_WIDTH-1:0]       r_mem_data  [DEPTH];
  logic [PtrW-1:0]             r_wr_ptr, r_rd_ptr;
  logic [LvlW-1:0]             r_level, w_level_d;
  logic                        r_cmd_ready;
  logic                        r_spi_start;
  logic [NUMBER_OF_SLAVES-1:0] r_spi_slave, r_rsp_slave;
  logic [DATA_WIDTH-1:0]       r_spi_tx_data, r_rsp_data;
  logic                        r_rsp_valid;

  logic w_push, w_pop, w_capture, w_timeout, w_rsp_clear;

`ifdef QUICK_SPI_TXN_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_timer;
  logic        r_rsp_error;
`endif

  assign w_push = cmd_valid && r_cmd_ready;

  always_comb begin
    w_state_d   = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_rsp_clear = 1'b0;
    case (r_state)
      StIdle: begin
        if (r_level != '0) begin
          w_pop     = 1'b1;
          w_state_d = StIssue;
        end
      end
      StIssue: w_state_d = StWaitDone;
      StWaitDone: begin
        // A done arriving on the timeout cycle takes priority over the timeout.
        if (spi_done) begin
          w_capture = 1'b1;
          w_state_d = StRespond;
        end
`ifdef QUICK_SPI_TXN_TIMEOUT_EN
        else if (r_timer == TimeoutLast) begin
          w_timeout = 1'b1;
          w_state_d = StRespond;
        end
`endif
      end
      StRespond: begin
        if (rsp_ready) begin
          w_rsp_clear = 1'b1;
          w_state_d   = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_level_d = r_level;
    if (w_push && !w_pop) begin
      w_level_d = r_level + LvlW'(1);
    end else if (!w_push && w_pop) begin
      w_level_d = r_level - LvlW'(1);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_slave[r_wr_ptr] <= cmd_slave;
      r_mem_data[r_wr_ptr]  <= cmd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= StIdle;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_cmd_ready   <= 1'b1;
      r_spi_start   <= 1'b0;
      r_spi_slave   <= '0;
      r_spi_tx_data <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_slave   <= '0;
      r_rsp_data    <= '0;
    end else begin
      r_state     <= w_state_d;
      r_level     <= w_level_d;
      r_cmd_ready <= (w_level_d != LvlW'(DEPTH));
      r_spi_start <= (r_state == StIssue);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr      <= r_rd_ptr + PtrW'(1);
        r_spi_slave   <= r_mem_slave[r_rd_ptr];
        r_spi_tx_data <= r_mem_data[r_rd_ptr];
      end
      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_slave <= r_spi_slave;
        r_rsp_data  <= spi_rx_data;
      end else if (w_timeout) begin
        r_rsp_valid <= 1'b1;
        r_rsp_slave <= r_spi_slave;
        r_rsp_data  <= '0;
      end else if (w_rsp_clear) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

`ifdef QUICK_SPI_TXN_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_timer     <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      r_timer <= (r_state == StWaitDone) ? r_timer + 16'd1 : 16'd0;
      if (w_capture || w_rsp_clear) begin
        r_rsp_error <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_error <= 1'b1;
      end
    end
  end

  assign rsp_error = r_rsp_error;
`endif

  assign cmd_ready   = r_cmd_ready;
  assign spi_start   = r_spi_start;
  assign spi_slave   = r_spi_slave;
  assign spi_tx_data = r_spi_tx_data;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_slave   = r_rsp_slave;
  assign rsp_data    = r_rsp_data;
  assign level       = r_level;

endmodule

// File: tb/tb_quick_spi_txn_queue.sv
// Directed bench for quick_spi_txn_queue; timeout steps build only with QUICK_SPI_TXN_TIMEOUT_EN.
module tb_quick_spi_txn_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_slave;
  logic [15:0] cmd_data;
  logic        spi_start;
  logic [1:0]  spi_slave;
  logic [15:0] spi_tx_data;
  logic        spi_done;
  logic [15:0] spi_rx_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_slave;
  logic [15:0] rsp_data;
  logic [3:0]  level;
`ifdef QUICK_SPI_TXN_TIMEOUT_EN
  logic        rsp_error;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  quick_spi_txn_queue #(
    .NUMBER_OF_SLAVES(2),
    .DATA_WIDTH(16),
    .DEPTH(8)
`ifdef QUICK_SPI_TXN_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_slave(cmd_slave),
    .cmd_data(cmd_data),
    .spi_start(spi_start),
    .spi_slave(spi_slave),
    .spi_tx_data(spi_tx_data),
    .spi_done(spi_done),
    .spi_rx_data(spi_rx_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_slave(rsp_slave),
    .rsp_data(rsp_data),
`ifdef QUICK_SPI_TXN_TIMEOUT_EN
    .rsp_error(rsp_error),
`endif
    .level(level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (spi_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, spi_start}, 32'd1);
  endtask

  task automatic done_pulse(input logic [15:0] rx);
    spi_done    = 1'b1;
    spi_rx_data = rx;
    tick();
    spi_done    = 1'b0;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  logic [15:0] exp_rsp [8] = '{16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFB,
                               16'hFFFA, 16'hFFF9, 16'hFFF8, 16'hFFF7};
  logic [15:0] exp_ord [4] = '{16'h0A01, 16'h0B02, 16'h0C03, 16'h0D04};

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_slave = 2'b00; cmd_data = 16'h0;
    spi_done = 1'b0; spi_rx_data = 16'h0; rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_level", level, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_spi_start", spi_start, 0);
    chk("rst_spi_slave", spi_slave, 0);
    chk("rst_spi_tx", spi_tx_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_slave", rsp_slave, 0);
    chk("rst_rsp_data", rsp_data, 0);
    reset_n = 1'b1;
    tick();

    // Single transaction
    cmd_valid = 1'b1; cmd_slave = 2'b01; cmd_data = 16'h1A6A;
    tick();
    cmd_valid = 1'b0;
    chk("t1_level_after_push", level, 1);
    chk("t1_start_n1", spi_start, 0);
    tick();
    chk("t1_start_n2", spi_start, 0);
    chk("t1_tx_loaded", spi_tx_data, 16'h1A6A);
    chk("t1_level_popped", level, 0);
    tick();
    chk("t1_start_pulse", spi_start, 1);
    chk("t1_spi_slave", spi_slave, 2'b01);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_start_low", spi_start, 0);
    end
    tick();
    done_pulse(16'h00C3);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_data", rsp_data, 16'h00C3);
    chk("t1_rsp_slave", rsp_slave, 2'b01);
`ifdef QUICK_SPI_TXN_TIMEOUT_EN
    chk("t1_rsp_error", rsp_error, 0);
`endif

    // Backpressure while filling the FIFO; the 9th push attempt must be refused
    for (int c = 0; c < 20; c++) begin
      cmd_valid = (c < 9);
      cmd_slave = c[0] ? 2'b10 : 2'b01;
      cmd_data  = 16'(c + 1);
      tick();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, 16'h00C3);
      chk("bp_rsp_slave", rsp_slave, 2'b01);
      chk("bp_no_start", spi_start, 0);
      if (c == 7) begin
        chk("fill_level8", level, 8);
        chk("fill_not_ready", cmd_ready, 0);
      end
    end
    cmd_valid = 1'b0;
    chk("fill_level_held", level, 8);
    chk("fill_ready_held", cmd_ready, 0);

    release_rsp();
    chk("bp_rsp_cleared", rsp_valid, 0);
    chk("bp_r0_start", spi_start, 0);
    chk("bp_r0_level", level, 8);
    tick();
    chk("bp_r1_start", spi_start, 0);
    chk("bp_r1_level", level, 7);
    chk("bp_r1_ready", cmd_ready, 1);
    chk("bp_r1_tx", spi_tx_data, 16'h0001);
    tick();
    chk("bp_r2_start", spi_start, 1);

    // Service all eight in order; last response stays pending
    for (int i = 0; i < 8; i++) begin
      wait_start("ord_start");
      chk("ord_tx", spi_tx_data, 16'(i + 1));
      done_pulse(16'(i + 1) ^ 16'hFFFF);
      chk("ord_rsp_valid", rsp_valid, 1);
      chk("ord_rsp_data", rsp_data, exp_rsp[i]);
      chk("ord_rsp_slave", rsp_slave, (i % 2 == 1) ? 2'b10 : 2'b01);
      if (i < 7) release_rsp();
    end

    // Simultaneous push and pop with level 3
    cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cmd_slave = 2'b01;
      cmd_data  = exp_ord[k];
      tick();
    end
    cmd_valid = 1'b0;
    chk("sim_level3", level, 3);
    release_rsp();
    chk("sim_idle_level", level, 3);
    cmd_valid = 1'b1; cmd_slave = 2'b10; cmd_data = exp_ord[3];
    tick();
    cmd_valid = 1'b0;
    chk("sim_level_same", level, 3);
    chk("sim_head_tx", spi_tx_data, exp_ord[0]);
    for (int j = 0; j < 4; j++) begin
      wait_start("sim_start");
      chk("sim_tx_order", spi_tx_data, exp_ord[j]);
      done_pulse(exp_ord[j]);
      chk("sim_rsp_data", rsp_data, exp_ord[j]);
      release_rsp();
    end

    // Reset in WAIT_DONE with level 4
    cmd_valid = 1'b1; cmd_slave = 2'b01;
    for (int k = 0; k < 5; k++) begin
      cmd_data = 16'h1001 + 16'(k);
      tick();
    end
    cmd_valid = 1'b0;
    chk("rr_level4", level, 4);
    chk("rr_tx_inflight", spi_tx_data, 16'h1001);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rr_level0", level, 0);
    chk("rr_rsp_valid", rsp_valid, 0);
    chk("rr_tx_cleared", spi_tx_data, 0);
    chk("rr_ready", cmd_ready, 1);
    done_pulse(16'hBEEF);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_stray_no_rsp", rsp_valid, 0);
      chk("rr_stray_no_start", spi_start, 0);
    end

`ifdef QUICK_SPI_TXN_TIMEOUT_EN
    // Timeout: never answer; response 16 cycles after entering WAIT_DONE
    cmd_valid = 1'b1; cmd_slave = 2'b10; cmd_data = 16'h7777;
    tick();
    cmd_valid = 1'b0;
    wait_start("to_start");
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("to_not_yet", rsp_valid, 0);
    end
    tick();
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_error", rsp_error, 1);
    chk("to_rsp_data", rsp_data, 0);
    chk("to_rsp_slave", rsp_slave, 2'b10);
    release_rsp();
    chk("to_cleared", rsp_valid, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
